// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Instruction fetch stage. Issues word reads to instruction memory, holds
//   the fetched instruction together with its PC and PC+4 in output registers
//   for the decode stage, and honours back-pressure (stall) and downstream
//   branch/jump redirects. A redirect that hits an access still waiting for
//   its data moves the FSM into DRAIN, where the old request is kept on the
//   bus until it completes and its data is thrown away.
//
// Optional feature:
//   EARLY_JUMP_EN - when defined, j (6'b111000) and jal (6'b111001) are
//   recognised in the returned word and the PC jumps straight to the target
//   instead of PC+4. A downstream redirect still takes priority.
//
// Parameters:
//   RESET_PC     - PC loaded while rst_n is low.
//
// Ports:
//   clk          in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   imem_req     out  1  instruction memory read request
//   imem_addr    out 32  word address of the request
//   imem_ready   in   1  read data valid; access completes on req & ready
//   imem_rdata   in  32  instruction word
//   stall        in   1  decode cannot accept; hold the current output
//   redirect     in   1  flush and reload PC from redirect_pc
//   redirect_pc  in  32  redirect target (low two bits ignored)
//   if_valid     out  1  if_* outputs carry a valid instruction
//   if_instr     out 32  fetched instruction
//   if_pc        out 32  PC of the fetched instruction
//   if_pc_plus4  out 32  PC + 4 of the fetched instruction
//   opcode       out  6  if_instr[31:26]
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_drain_addr;   // address of the abandoned access kept on the bus in DRAIN
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc_plus4;

  logic        w_req;
  logic        w_done;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_next_pc;

  // 32-bit add wraps naturally, so 0xFFFF_FFFC advances to 0.
  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
  assign w_done        = w_req & imem_ready;

`ifdef EARLY_JUMP_EN
  logic w_is_jump;
  // j = 111000, jal = 111001: only bit 26 differs.
  assign w_is_jump = (imem_rdata[31:27] == 5'b11100);
  assign w_next_pc = w_is_jump ? {w_pc_plus4[31:28], imem_rdata[25:0], 2'b00}
                               : w_pc_plus4;
`else
  assign w_next_pc = w_pc_plus4;
`endif

  // The request must react to stall in the same cycle, so it is decoded
  // from the registered state rather than registered itself.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH: w_req = ~(r_if_valid & stall);
      S_DRAIN: w_req = 1'b1;
      default: w_req = 1'b0;
    endcase
  end

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign opcode      = r_if_instr[31:26];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_drain_addr  <= 32'h0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'h0;
      r_if_pc       <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_FETCH;
          r_if_valid <= 1'b0;
        end

        S_FETCH: begin
          if (redirect) begin
            r_pc       <= w_redirect_pc;
            r_if_valid <= 1'b0;
            // An access still waiting for data cannot be withdrawn; park it
            // in DRAIN on its original address until memory answers.
            if (w_req && !imem_ready) begin
              r_state      <= S_DRAIN;
              r_drain_addr <= r_pc;
            end
          end else if (w_done) begin
            r_if_instr    <= imem_rdata;
            r_if_pc       <= r_pc;
            r_if_pc_plus4 <= w_pc_plus4;
            r_if_valid    <= 1'b1;
            r_pc          <= w_next_pc;
          end else if (!stall) begin
            r_if_valid <= 1'b0;
          end
        end

        S_DRAIN: begin
          r_if_valid <= 1'b0;
          if (redirect) begin
            r_pc <= w_redirect_pc;
          end else if (imem_ready) begin
            // Stale data is dropped; resume at the redirected PC.
            r_state <= S_FETCH;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
